// File: rtl/led_flicker_amm_master.sv
// Avalon-MM initiator for the led_flicker register block: one single-word
// read/write (optionally write-then-verify) transaction per command.
module led_flicker_amm_master #(
   parameter int unsigned       ADDR_W         = 1,
   parameter int unsigned       DATA_W         = 32,
   parameter logic [DATA_W-1:0] VERIFY_MASK    = DATA_W'(32'h0000_FFFF),
   parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              srst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic              cmd_verify_i,
   input  logic [ADDR_W-1:0] cmd_address_i,
   input  logic [DATA_W-1:0] cmd_writedata_i,
   output logic              rsp_valid_o,
   output logic [1:0]        rsp_status_o,
   output logic [DATA_W-1:0] rsp_readdata_o,
   output logic [ADDR_W-1:0] amm_address_o,
   output logic [DATA_W-1:0] amm_writedata_o,
   output logic              amm_read_o,
   output logic              amm_write_o,
   input  logic [DATA_W-1:0] amm_readdata_i,
   input  logic              amm_readdatavalid_i,
   input  logic              amm_waitrequest_i
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] RSP_OK       = 2'b00;
   localparam logic [1:0] RSP_MISMATCH = 2'b01;
   localparam logic [1:0] RSP_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR,
      S_RD_REQ,
      S_RD_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               verify_q, verify_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdata_d;
   logic               rsp_valid_d;
   logic [1:0]         rsp_status_d;
   logic [DATA_W-1:0]  rsp_data_d;
   logic               timed_out;
   logic               readback_bad;

   assign timed_out    = (timer_q == CNT_LAST);
   assign readback_bad = |((amm_readdata_i ^ amm_writedata_o) & VERIFY_MASK);

   always_comb begin
      state_d      = state_q;
      verify_d     = verify_q;
      addr_d       = amm_address_o;
      wdata_d      = amm_writedata_o;
      rsp_valid_d  = 1'b0;
      rsp_status_d = rsp_status_o;
      rsp_data_d   = rsp_readdata_o;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               verify_d = cmd_write_i & cmd_verify_i;
               addr_d   = cmd_address_i;
               wdata_d  = cmd_writedata_i;
               state_d  = cmd_write_i ? S_WR : S_RD_REQ;
            end
         end
         S_WR: begin
            if (!amm_waitrequest_i) begin
               if (verify_q) begin
                  state_d = S_RD_REQ;
               end else begin
                  state_d      = S_IDLE;
                  rsp_valid_d  = 1'b1;
                  rsp_status_d = RSP_OK;
                  rsp_data_d   = '0;
               end
            end else if (timed_out) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
               rsp_data_d   = '0;
            end
         end
         S_RD_REQ: begin
            if (!amm_waitrequest_i) begin
               state_d = S_RD_WAIT;
            end else if (timed_out) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
               rsp_data_d   = '0;
            end
         end
         S_RD_WAIT: begin
            // Completion takes priority over a timeout expiring in the same cycle.
            if (amm_readdatavalid_i) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = (verify_q && readback_bad) ? RSP_MISMATCH : RSP_OK;
               rsp_data_d   = amm_readdata_i;
            end else if (timed_out) begin
               state_d      = S_IDLE;
               rsp_valid_d  = 1'b1;
               rsp_status_d = RSP_TIMEOUT;
               rsp_data_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Every state change (including WR -> RD_REQ) restarts the phase timer.
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q         <= S_IDLE;
         timer_q         <= '0;
         verify_q        <= 1'b0;
         cmd_ready_o     <= 1'b1;
         rsp_valid_o     <= 1'b0;
         rsp_status_o    <= '0;
         rsp_readdata_o  <= '0;
         amm_address_o   <= '0;
         amm_writedata_o <= '0;
         amm_read_o      <= 1'b0;
         amm_write_o     <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         verify_q        <= verify_d;
         cmd_ready_o     <= (state_d == S_IDLE);
         rsp_valid_o     <= rsp_valid_d;
         rsp_status_o    <= rsp_status_d;
         rsp_readdata_o  <= rsp_data_d;
         amm_address_o   <= addr_d;
         amm_writedata_o <= wdata_d;
         amm_read_o      <= (state_d == S_RD_REQ);
         amm_write_o     <= (state_d == S_WR);
      end
   end

endmodule
